// File: rtl/gpio_mul_pkg.sv
// Shared types and constants for the GPIO-attached shift-add multiply / popcount engine.
package gpio_mul_pkg;

  localparam int unsigned OP_W       = 24;
  localparam int unsigned W_W        = 32;
  localparam int unsigned PROD_W     = 2 * OP_W;
  localparam int unsigned POPC_W     = 6;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned MULT_STEPS = 24;
  localparam int unsigned POPC_STEPS = 32;
  localparam int unsigned MSTEP_W    = 5;
  localparam int unsigned PSTEP_W    = 5;

  // Status-word bit positions; the sticky done bit is held by the register block.
  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_DONE_BIT = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMult = 2'd1,
    StPopc = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/gpio_shift_add_mul.sv
// MULT-phase datapath: serial shift-add multiplier with a full-width accumulator.
module gpio_shift_add_mul
  import gpio_mul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [OP_W-1:0]   a1,
  input  logic [OP_W-1:0]   a2,
  output logic [PROD_W-1:0] acc,
  output logic [W_W-1:0]    acc_lo_next,
  output logic              last
);

  logic [PROD_W-1:0]  mcand_q;
  logic [OP_W-1:0]    mplier_q;
  logic [PROD_W-1:0]  acc_q;
  logic [PROD_W-1:0]  acc_d;
  logic [MSTEP_W-1:0] step_q;

  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign acc         = acc_q;
  // Low word after the current add, so POPC can load on the final MULT edge.
  assign acc_lo_next = acc_d[W_W-1:0];
  assign last        = (step_q == MSTEP_W'(MULT_STEPS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      step_q   <= '0;
    end else if (load) begin
      mcand_q  <= {{(PROD_W - OP_W){1'b0}}, a1};
      mplier_q <= a2;
      acc_q    <= '0;
      step_q   <= '0;
    end else if (step) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      step_q   <= step_q + MSTEP_W'(1);
    end
  end

endmodule

// File: rtl/gpio_mul_core.sv
// Multiply-and-popcount engine behind the GPIO register block; FSM and POPC phase live here.
module gpio_mul_core
  import gpio_mul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   a1,
  input  logic [OP_W-1:0]   a2,
  output logic              busy,
  output logic              done,
  output logic [W_W-1:0]    w,
  output logic [POPC_W-1:0] l,
  output logic              ovf,
  output logic [CNT_W-1:0]  op_count
);

  state_e             state_q;
  logic [W_W-1:0]     shift_q;
  logic [POPC_W-1:0]  pcnt_q;
  logic [PSTEP_W-1:0] pstep_q;

  logic [PROD_W-1:0]  acc;
  logic [W_W-1:0]     acc_lo_next;
  logic               mult_last;
  logic               load;
  logic [POPC_W-1:0]  pcnt_next;

  assign load      = (state_q == StIdle) && start;
  assign pcnt_next = pcnt_q + POPC_W'(shift_q[0]);

  gpio_shift_add_mul u_mul (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step        (state_q == StMult),
    .a1          (a1),
    .a2          (a2),
    .acc         (acc),
    .acc_lo_next (acc_lo_next),
    .last        (mult_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      pcnt_q   <= '0;
      pstep_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      w        <= '0;
      l        <= '0;
      ovf      <= 1'b0;
      op_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StMult;
            busy    <= 1'b1;
          end
        end
        StMult: begin
          if (mult_last) begin
            state_q <= StPopc;
            shift_q <= acc_lo_next;
            pcnt_q  <= '0;
            pstep_q <= '0;
          end
        end
        StPopc: begin
          shift_q <= shift_q >> 1;
          pcnt_q  <= pcnt_next;
          pstep_q <= pstep_q + PSTEP_W'(1);
          if (pstep_q == PSTEP_W'(POPC_STEPS - 1)) begin
            state_q  <= StDone;
            busy     <= 1'b0;
            done     <= 1'b1;
            w        <= acc[W_W-1:0];
            l        <= pcnt_next;
            ovf      <= |acc[PROD_W-1:W_W];
            op_count <= op_count + CNT_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_mul_core.sv
// Scoreboard bench for gpio_mul_core: driver pushes expected results, monitor checks on done.
module tb_gpio_mul_core;
  import gpio_mul_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [OP_W-1:0]   a1 = '0;
  logic [OP_W-1:0]   a2 = '0;
  logic              busy;
  logic              done;
  logic [W_W-1:0]    w;
  logic [POPC_W-1:0] l;
  logic              ovf;
  logic [CNT_W-1:0]  op_count;

  typedef struct {
    logic [W_W-1:0]    w;
    logic [POPC_W-1:0] l;
    logic              ovf;
    logic [CNT_W-1:0]  cnt;
    int unsigned       acc_cyc;
  } exp_t;

  exp_t             sb[$];
  int unsigned      cyc = 0;
  int unsigned      n_vec = 0;
  int unsigned      n_bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             done_prev = 1'b0;

  gpio_mul_core dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a1       (a1),
    .a2       (a2),
    .busy     (busy),
    .done     (done),
    .w        (w),
    .l        (l),
    .ovf      (ovf),
    .op_count (op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset) begin
      done_prev = 1'b0;
    end else begin
      if (done) begin
        check("done_width", {63'b0, done_prev}, 64'd0);
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("w", {32'b0, w}, {32'b0, e.w});
          check("l", {58'b0, l}, {58'b0, e.l});
          check("ovf", {63'b0, ovf}, {63'b0, e.ovf});
          check("op_count", {56'b0, op_count}, {56'b0, e.cnt});
          check("latency", 64'(cyc - e.acc_cyc), 64'd56);
        end
      end
      done_prev = done;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout: got busy=%0b done=%0b, expected idle", busy, done);
    end
  endtask

  task automatic issue(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y,
                       input logic [W_W-1:0] ew, input logic [POPC_W-1:0] el, input logic eo);
    exp_t e;
    wait_idle();
    a1    = x;
    a2    = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    e.w       = ew;
    e.l       = el;
    e.ovf     = eo;
    e.cnt     = exp_cnt;
    e.acc_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, {63'b0, busy}, 64'd0);
    check({tag, "_done"}, {63'b0, done}, 64'd0);
    check({tag, "_w"}, {32'b0, w}, 64'd0);
    check({tag, "_l"}, {58'b0, l}, 64'd0);
    check({tag, "_ovf"}, {63'b0, ovf}, 64'd0);
    check({tag, "_op_count"}, {56'b0, op_count}, 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero_outputs("reset");

    issue(24'd3, 24'd5, 32'h0000_000F, 6'd4, 1'b0);
    issue(24'hFF_FFFF, 24'hFF_FFFF, 32'hFE00_0001, 6'd8, 1'b1);
    issue(24'h01_0000, 24'h01_0000, 32'h0, 6'd0, 1'b1);
    issue(24'h00_0000, 24'h12_3456, 32'h0, 6'd0, 1'b0);

    // Start re-pulsed in MULT and DONE with new operands must be ignored.
    issue(24'd2, 24'd7, 32'h0000_000E, 6'd3, 1'b0);
    repeat (5) @(negedge clk);
    check("busy_in_mult", {63'b0, busy}, 64'd1);
    a1    = 24'hFF_FFFF;
    a2    = 24'hFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {63'b0, done}, 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_after_done", {63'b0, busy}, 64'd0);
    repeat (70) @(negedge clk);

    // Abort in POPC: no done pulse, every output cleared.
    wait_idle();
    a1    = 24'd3;
    a2    = 24'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("busy_in_popc", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero_outputs("midreset");
    exp_cnt = '0;
    repeat (70) @(negedge clk);

    for (int i = 0; i < 256; i++) begin
      issue(24'd1, 24'd1, 32'h1, 6'd1, 1'b0);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
    check("wrap_op_count", {56'b0, op_count}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
